// File: rtl/display_timing_pkg.sv
// ============================================================================
// Module      : display_timing_pkg
// Description : Default 1280x1024@60 timing, colour-bar table, sync decode.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package display_timing_pkg;

  localparam int unsigned C_H_ACTIVE = 1280;
  localparam int unsigned C_H_FP     = 48;
  localparam int unsigned C_H_SYNC   = 112;
  localparam int unsigned C_H_BP     = 248;
  localparam int unsigned C_H_TOTAL  = C_H_ACTIVE + C_H_FP + C_H_SYNC + C_H_BP;

  localparam int unsigned C_V_ACTIVE = 1024;
  localparam int unsigned C_V_FP     = 1;
  localparam int unsigned C_V_SYNC   = 3;
  localparam int unsigned C_V_BP     = 38;
  localparam int unsigned C_V_TOTAL  = C_V_ACTIVE + C_V_FP + C_V_SYNC + C_V_BP;

  // Index 0 is the leftmost bar.
  localparam logic [7:0][23:0] C_BAR_TABLE = {
    24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
    24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
  };

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
  } sync_t;

  typedef struct packed {
    logic       pat_en;
    logic [2:0] bar_idx;
  } pattern_t;

  function automatic logic in_window(input int unsigned cnt,
                                     input int unsigned start,
                                     input int unsigned len);
    return (cnt >= start) && (cnt < start + len);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_delay_line.sv
// ============================================================================
// Module      : sync_delay_line
// Description : DEPTH-stage shift register with async active-low clear.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module sync_delay_line #(
  parameter int unsigned          WIDTH     = 3,
  parameter int unsigned          DEPTH     = 2,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_pipe [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) r_pipe[i] <= RESET_VAL;
    end else begin
      r_pipe[0] <= i_data;
      for (int i = 1; i < int'(DEPTH); i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_data = r_pipe[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/display_timing_gen.sv
// ============================================================================
// Module      : display_timing_gen
// Description : Raster timing generator with latency-matched panel outputs.
//               Optional colour bars under DISPLAY_TIMING_TEST_PATTERN_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module display_timing_gen
  import display_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = C_H_ACTIVE,
  parameter int unsigned H_FP       = C_H_FP,
  parameter int unsigned H_SYNC     = C_H_SYNC,
  parameter int unsigned H_BP       = C_H_BP,
  parameter int unsigned V_ACTIVE   = C_V_ACTIVE,
  parameter int unsigned V_FP       = C_V_FP,
  parameter int unsigned V_SYNC     = C_V_SYNC,
  parameter int unsigned V_BP       = C_V_BP,
  parameter bit          SYNC_POL   = 1'b1,
  parameter int unsigned PIPE_DELAY = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic        valid,
  output logic        vsync,
  output logic        frame_start,
  input  logic [23:0] rgb_in,
  input  logic        test_mode,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        de_out,
  output logic [23:0] rgb_out
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);

  localparam sync_t C_SYNC_IDLE = '{hsync: ~SYNC_POL, vsync: ~SYNC_POL, de: 1'b0};

`ifdef DISPLAY_TIMING_TEST_PATTERN_EN
  localparam int unsigned DLY_W = $bits(sync_t) + $bits(pattern_t);
`else
  localparam int unsigned DLY_W = $bits(sync_t);
`endif
  localparam logic [DLY_W-1:0] C_DLY_RST = DLY_W'(C_SYNC_IDLE);

  logic [HW-1:0]    r_h_cnt;
  logic [VW-1:0]    r_v_cnt;
  logic             r_hsync;
  logic             w_h_last;
  logic             w_h_active;
  logic             w_v_active;
  logic             w_hs_win;
  logic             w_vs_win;
  logic [DLY_W-1:0] w_dly_in;
  logic [DLY_W-1:0] w_dly_out;
  sync_t            w_sync_in;
  sync_t            w_sync_dly;
  logic [23:0]      w_pixel;

  assign w_h_last   = (r_h_cnt == HW'(H_TOTAL - 1));
  assign w_h_active = (r_h_cnt < HW'(H_ACTIVE));
  assign w_v_active = (r_v_cnt < VW'(V_ACTIVE));
  assign w_hs_win   = in_window(32'(r_h_cnt), H_ACTIVE + H_FP, H_SYNC);
  assign w_vs_win   = in_window(32'(r_v_cnt), V_ACTIVE + V_FP, V_SYNC);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_h_last) begin
      r_h_cnt <= '0;
      r_v_cnt <= (r_v_cnt == VW'(V_TOTAL - 1)) ? '0 : r_v_cnt + 1'b1;
    end else begin
      r_h_cnt <= r_h_cnt + 1'b1;
    end
  end

  // Consumer-facing stage: decodes the counter state captured at this edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x           <= '0;
      y           <= '0;
      valid       <= 1'b0;
      frame_start <= 1'b0;
      vsync       <= ~SYNC_POL;
      r_hsync     <= ~SYNC_POL;
    end else begin
      x           <= w_h_active ? 11'(r_h_cnt) : '0;
      y           <= w_v_active ? 10'(r_v_cnt) : '0;
      valid       <= w_h_active && w_v_active;
      frame_start <= (r_h_cnt == '0) && (r_v_cnt == '0);
      vsync       <= w_vs_win ? SYNC_POL : ~SYNC_POL;
      r_hsync     <= w_hs_win ? SYNC_POL : ~SYNC_POL;
    end
  end

  assign w_sync_in = '{hsync: r_hsync, vsync: vsync, de: valid};

`ifdef DISPLAY_TIMING_TEST_PATTERN_EN
  logic     r_pat_en;
  logic     w_pat_en;
  pattern_t w_pat_in;
  pattern_t w_pat_dly;

  // Mode only changes on the first pixel of a frame to avoid tearing.
  assign w_pat_en = frame_start ? test_mode : r_pat_en;
  assign w_pat_in = '{pat_en: w_pat_en, bar_idx: 3'(x / 11'(H_ACTIVE / 8))};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_pat_en <= 1'b0;
    else        r_pat_en <= w_pat_en;
  end

  assign w_dly_in   = {w_pat_in, w_sync_in};
  assign w_pat_dly  = w_dly_out[DLY_W-1 -: $bits(pattern_t)];
  assign w_pixel    = w_pat_dly.pat_en ? C_BAR_TABLE[w_pat_dly.bar_idx] : rgb_in;
`else
  logic w_unused_test_mode;
  assign w_unused_test_mode = test_mode;
  assign w_dly_in           = w_sync_in;
  assign w_pixel            = rgb_in;
`endif

  assign w_sync_dly = w_dly_out[$bits(sync_t)-1:0];

  sync_delay_line #(
    .WIDTH     (DLY_W),
    .DEPTH     (PIPE_DELAY),
    .RESET_VAL (C_DLY_RST)
  ) u_sync_delay_line (
    .clk    (clk),
    .rst_n  (reset),
    .i_data (w_dly_in),
    .o_data (w_dly_out)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hsync_out <= ~SYNC_POL;
      vsync_out <= ~SYNC_POL;
      de_out    <= 1'b0;
      rgb_out   <= '0;
    end else begin
      hsync_out <= w_sync_dly.hsync;
      vsync_out <= w_sync_dly.vsync;
      de_out    <= w_sync_dly.de;
      rgb_out   <= w_sync_dly.de ? w_pixel : '0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_display_timing_gen.sv
// ============================================================================
// Module      : tb_display_timing_gen
// Description : Directed self-checking bench; full horizontal timing, short
//               vertical timing (14 lines) to keep the run short.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_display_timing_gen;

  localparam int H_TOT = 1688;
  localparam int V_TOT = 14;
  localparam int FRAME = H_TOT * V_TOT;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [10:0] x;
  logic [9:0]  y;
  logic        valid, vsync, frame_start;
  logic [23:0] rgb_in;
  logic        test_mode = 1'b0;
  logic        hsync_out, vsync_out, de_out;
  logic [23:0] rgb_out;

  logic [23:0] p1 = '0, p2 = '0;
  logic        rgb_override = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  display_timing_gen #(
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(3), .V_BP(2), .SYNC_POL(1'b1), .PIPE_DELAY(2)
  ) dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .valid(valid), .vsync(vsync),
    .frame_start(frame_start), .rgb_in(rgb_in), .test_mode(test_mode),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .de_out(de_out), .rgb_out(rgb_out)
  );

  // Two-cycle consumer model returning {x, y, A5}.
  always @(posedge clk) begin
    p1 <= {x[7:0], y[7:0], 8'hA5};
    p2 <= p1;
  end
  assign rgb_in = rgb_override ? 24'hFFFFFF : p2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic goto(input int target);
    repeat (target - cyc) @(posedge clk);
    #1;
    cyc = target;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    cyc = 0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_x", 32'(x), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_fs", 32'(frame_start), 0);
    chk("rst_vsync", 32'(vsync), 0);
    chk("rst_hsync_out", 32'(hsync_out), 0);
    chk("rst_de_out", 32'(de_out), 0);
    chk("rst_rgb_out", 32'(rgb_out), 0);

    release_reset();
    chk("c0_x", 32'(x), 0);
    chk("c0_y", 32'(y), 0);
    chk("c0_valid", 32'(valid), 1);
    chk("c0_fs", 32'(frame_start), 1);

    goto(8);
    chk("align_rgb_x5", 32'(rgb_out), 32'h0500A5);
    chk("align_de_x5", 32'(de_out), 1);
    chk("c8_fs", 32'(frame_start), 0);

    goto(1279);
    chk("c1279_x", 32'(x), 1279);
    chk("c1279_valid", 32'(valid), 1);
    goto(1280);
    chk("c1280_x", 32'(x), 0);
    chk("c1280_valid", 32'(valid), 0);
    goto(1282);
    chk("last_px_rgb", 32'(rgb_out), 32'hFF00A5);
    goto(1283);
    chk("blank_de", 32'(de_out), 0);
    rgb_override = 1'b1;
    goto(1290);
    chk("blank_rgb_forced0", 32'(rgb_out), 0);
    rgb_override = 1'b0;

    goto(1330);
    chk("hs_before", 32'(hsync_out), 0);
    goto(1331);
    chk("hs_first", 32'(hsync_out), 1);
    goto(1442);
    chk("hs_last", 32'(hsync_out), 1);
    goto(1443);
    chk("hs_after", 32'(hsync_out), 0);

    goto(H_TOT);
    chk("line1_y", 32'(y), 1);
    chk("line1_x", 32'(x), 0);
    chk("line1_valid", 32'(valid), 1);
    goto(H_TOT + 1331);
    chk("hs_line1", 32'(hsync_out), 1);

    goto(7 * H_TOT + 1500);
    chk("y7_hblank", 32'(y), 7);
    goto(8 * H_TOT);
    chk("vblank_y", 32'(y), 0);
    chk("vblank_valid", 32'(valid), 0);

    goto(9 * H_TOT - 1);
    chk("vs_before", 32'(vsync), 0);
    goto(9 * H_TOT);
    chk("vs_first", 32'(vsync), 1);
    goto(12 * H_TOT - 1);
    chk("vs_last", 32'(vsync), 1);
    goto(12 * H_TOT);
    chk("vs_after", 32'(vsync), 0);
    goto(12 * H_TOT + 3);
    chk("vs_out_after", 32'(vsync_out), 0);

    goto(FRAME - 1);
    chk("fs_prev", 32'(frame_start), 0);
    goto(FRAME);
    chk("fs_period", 32'(frame_start), 1);
    chk("f1_y", 32'(y), 0);
    chk("f1_valid", 32'(valid), 1);

    goto(FRAME + 5 * H_TOT + 700);
    chk("pre_rst_x", 32'(x), 700);
    chk("pre_rst_y", 32'(y), 5);
    reset = 1'b0;
    #2;
    chk("async_rst_x", 32'(x), 0);
    chk("async_rst_y", 32'(y), 0);
    chk("async_rst_valid", 32'(valid), 0);
    chk("async_rst_de", 32'(de_out), 0);
    chk("async_rst_rgb", 32'(rgb_out), 0);
    repeat (2) @(posedge clk);
    release_reset();
    chk("restart_x", 32'(x), 0);
    chk("restart_y", 32'(y), 0);
    chk("restart_fs", 32'(frame_start), 1);

`ifdef DISPLAY_TIMING_TEST_PATTERN_EN
    goto(3 * H_TOT + 10);
    test_mode = 1'b1;
    goto(3 * H_TOT + 100);
    chk("pat_deferred", 32'(rgb_out), 32'h6103A5);
    goto(FRAME + 3);
    chk("pat_x0", 32'(rgb_out), 32'hFFFFFF);
    goto(FRAME + 163);
    chk("pat_x160", 32'(rgb_out), 32'hFFFF00);
    goto(FRAME + 1282);
    chk("pat_x1279", 32'(rgb_out), 32'h000000);
    chk("pat_x1279_de", 32'(de_out), 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
